// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a circular-buffer byte FIFO.
// Line bits are held CLKS_PER_BIT cycles; back-to-back frames leave no idle gap.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          uart_tx
);

    localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
    localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW       = PtrW + 1;
    localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);

    if (ClksPerBit < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // FIFO state
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic            overflow_q, overflow_d;
    logic            push, pop;
    logic [7:0]      rd_data;

    // Transmitter state
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;

    assign full     = (level_q == LvlW'(FIFO_DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != StIdle);
    assign uart_tx  = tx_q;

    // Acceptance uses the registered full flag, so a same-cycle pop never rescues a push.
    assign push    = wr_en && !full;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = wr_en && full;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LvlW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LvlW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // tx_d is the line level for the cycle that follows the transition being decided.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = rd_data;
                    cnt_d   = '0;
                    state_d = StStart;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (cnt_q == CntLast) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = StData;
                    tx_d      = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = rd_data;
                        state_d = StStart;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue/frame-arithmetic model checked every cycle, plus
// directed waveform points computed by hand for 10 clk/bit and a 4-entry FIFO.
module tb_uart_tx_fifo;

    localparam int unsigned Depth = 4;
    localparam int unsigned Cpb   = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, overflow, busy, uart_tx;
    logic [2:0] level;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    uart_tx_fifo #(
        .CLK_FREQ  (1000000),
        .BAUD_RATE (100000),
        .FIFO_DEPTH(Depth)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .overflow(overflow),
        .busy    (busy),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a byte queue plus the running frame as a 10-bit pattern indexed by elapsed time.
    logic [7:0] mq[$];
    bit         m_active;
    int         m_t;
    logic [9:0] m_frame;
    bit         m_ovf;
    bit         m_pop;
    int         m_sz;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_ovf    = 1'b0;
            m_frame  = 10'h3ff;
        end else begin
            m_sz  = mq.size();
            m_pop = (m_sz > 0) && (!m_active || m_t == 10 * Cpb - 1);
            m_ovf = wr_en && (m_sz == Depth);
            if (m_active) begin
                m_t++;
                if (m_t == 10 * Cpb) m_active = 1'b0;
            end
            if (m_pop) begin
                m_frame  = {1'b1, mq.pop_front(), 1'b0};
                m_active = 1'b1;
                m_t      = 0;
            end
            if (wr_en && m_sz < Depth) mq.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en && reset) begin
            check("m_tx", 32'(uart_tx), m_active ? 32'(m_frame[m_t / Cpb]) : 32'd1);
            check("m_busy", 32'(busy), 32'(m_active));
            check("m_level", 32'(level), 32'(mq.size()));
            check("m_full", 32'(full), 32'(mq.size() == Depth));
            check("m_empty", 32'(empty), 32'(mq.size() == 0));
            check("m_ovf", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || !empty) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 3000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    logic [7:0] a5_bits;
    int         cnt;
    bit         activity;

    initial begin
        // 1: reset
        repeat (5) @(negedge clk);
        check("rst_tx", 32'(uart_tx), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        check("post_rst_tx", 32'(uart_tx), 32'd1);
        check("post_rst_empty", 32'(empty), 32'd1);
        check("post_rst_level", 32'(level), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // 2: single 0xA5 frame
        push(8'hA5);
        check("a5_empty", 32'(empty), 32'd0);
        check("a5_tx_pre", 32'(uart_tx), 32'd1);
        @(negedge clk);
        check("a5_start", 32'(uart_tx), 32'd0);
        check("a5_busy", 32'(busy), 32'd1);
        a5_bits = 8'b1010_0101;
        repeat (15) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("a5_bit%0d", k), 32'(uart_tx), 32'(a5_bits[k]));
            repeat (10) @(negedge clk);
        end
        check("a5_stop", 32'(uart_tx), 32'd1);
        repeat (4) @(negedge clk);
        check("a5_busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        check("a5_busy_end", 32'(busy), 32'd0);
        wait_idle();

        // 3: burst, then overflow
        for (int i = 1; i <= 5; i++) push(8'(i));
        check("burst_level", 32'(level), 32'd4);
        check("burst_full", 32'(full), 32'd1);
        push(8'h06);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_level", 32'(level), 32'd4);
        @(negedge clk);
        check("ovf_clear", 32'(overflow), 32'd0);
        wait_idle();

        // 4: three back-to-back frames
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("b2b_busy", 32'(busy), 32'd1);
        cnt = 1;
        while (busy && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        check("b2b_cycles", 32'(cnt), 32'd300);
        wait_idle();

        // 5: reset mid-DATA
        push(8'h3C);
        push(8'h44);
        push(8'h55);
        repeat (40) @(negedge clk);
        check("mid_level", 32'(level), 32'd2);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_tx", 32'(uart_tx), 32'd1);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        activity = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) activity = 1'b1;
        end
        check("post_rst_silent", 32'(activity), 32'd0);

        // 6: push rejected at the pop edge while full
        push(8'h5A);
        push(8'h61);
        push(8'h62);
        push(8'h63);
        push(8'h64);
        check("t6_full", 32'(full), 32'd1);
        repeat (96) @(negedge clk);
        push(8'h77);
        check("t6_ovf", 32'(overflow), 32'd1);
        check("t6_level", 32'(level), 32'd3);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
